// File: rtl/clock_phase_monitor.sv
// clock_phase_monitor: measures a divided clock in clk cycles, locks onto DIV_RATIO periods and reports phase and errors
module clock_phase_monitor #(
  parameter int DIV_RATIO   = 4,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_clk_in,
  input  logic             enable,
  output logic             rise_pulse,
  output logic             locked,
  output logic [CNT_W-1:0] phase,
  output logic [CNT_W-1:0] last_period,
  output logic             period_err,
  output logic [7:0]       err_count
);
  typedef enum logic [1:0] {IDLE, SEARCH, ACQUIRE, LOCKED} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DIV     = CNT_W'(DIV_RATIO);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(2 * DIV_RATIO);
  localparam logic [CNT_W-1:0] LCK     = CNT_W'(LOCK_COUNT);
  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] s;
  logic                   prev, rise, tmo, err_n;
  logic [CNT_W-1:0]       cnt, cnt_n, good, good_n, per, lp_n;
  logic [7:0]             ec_n;
  assign rise  = s[SYNC_STAGES-1] & ~prev;
  assign per   = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
  assign tmo   = (cnt == TMO) & ~rise;
  assign cnt_n = (!enable || state == IDLE || rise) ? '0 : per;
  // next-state, period check and error accounting; a dropping enable overrides everything else
  always_comb begin
    state_n = state;
    good_n  = good;
    err_n   = 1'b0;
    ec_n    = err_count;
    lp_n    = last_period;
    if (!enable) begin
      state_n = IDLE;
      good_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = SEARCH;
          good_n  = '0;
        end
        SEARCH: if (rise) begin
          state_n = ACQUIRE;
          good_n  = '0;
          lp_n    = per;
        end
        ACQUIRE: if (rise) begin
          lp_n    = per;
          good_n  = (per == DIV) ? good + 1'b1 : '0;
          err_n   = per != DIV;
          state_n = (per == DIV && good + 1'b1 == LCK) ? LOCKED : ACQUIRE;
        end else if (tmo) begin
          err_n   = 1'b1;
          good_n  = '0;
          state_n = SEARCH;
        end
        default: begin
          lp_n = rise ? per : last_period;
          if ((rise && per != DIV) || tmo) begin
            err_n   = 1'b1;
            ec_n    = (err_count == 8'hff) ? err_count : err_count + 1'b1;
            good_n  = '0;
            state_n = rise ? ACQUIRE : SEARCH;
          end
        end
      endcase
    end
  end
  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  // synchroniser, period counter and registered outputs, all committed on the transition edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s           <= '0;
      prev        <= 1'b0;
      cnt         <= '0;
      good        <= '0;
      last_period <= '0;
      err_count   <= '0;
      rise_pulse  <= 1'b0;
      locked      <= 1'b0;
      phase       <= '0;
      period_err  <= 1'b0;
    end else begin
      s           <= {s[SYNC_STAGES-2:0], div_clk_in};
      prev        <= s[SYNC_STAGES-1];
      cnt         <= cnt_n;
      good        <= good_n;
      last_period <= lp_n;
      err_count   <= ec_n;
      rise_pulse  <= rise;
      locked      <= state_n == LOCKED;
      phase       <= (state_n == LOCKED) ? cnt_n : '0;
      period_err  <= err_n;
    end
  end
endmodule

// File: tb/tb_clock_phase_monitor.sv
// tb_clock_phase_monitor: scoreboard bench for clock_phase_monitor with DIV_RATIO=4, LOCK_COUNT=4
module tb_clock_phase_monitor;
  logic       clk = 1'b0, reset = 1'b1, div_clk_in = 1'b0, enable = 1'b0;
  logic       rise_pulse, locked, period_err;
  logic [7:0] phase, last_period, err_count;
  typedef struct {
    logic rp;
    logic err;
    logic lk;
    int   lp;
    int   ec;
    int   gap;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int   checks = 0, failures = 0;
  int   cyc = 0, last_rp = 0, since_rise = 0;
  bit   chk_phase = 1'b0;

  clock_phase_monitor #(.DIV_RATIO(4), .LOCK_COUNT(4), .CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .div_clk_in(div_clk_in), .enable(enable),
    .rise_pulse(rise_pulse), .locked(locked), .phase(phase),
    .last_period(last_period), .period_err(period_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every rise_pulse or period_err must match the next queued expectation
  always @(negedge clk) begin
    cyc++;
    since_rise = rise_pulse ? 0 : since_rise + 1;
    if (chk_phase) check("phase", phase, since_rise);
    if (!reset && (rise_pulse || period_err)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event rise_pulse=%0b period_err=%0b at %0t", rise_pulse, period_err, $time);
      end else begin
        e = q.pop_front();
        check("ev_rise_pulse", rise_pulse, e.rp);
        check("ev_period_err", period_err, e.err);
        check("ev_locked", locked, e.lk);
        check("ev_err_count", err_count, e.ec);
        if (e.lp >= 0) check("ev_last_period", last_period, e.lp);
        if (e.gap > 0) check("timeout_gap", cyc - last_rp, e.gap);
      end
      if (rise_pulse) last_rp = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(bit rp, bit err, bit lk, int lp, int ec, int gap);
    exp_t x;
    x.rp = rp; x.err = err; x.lk = lk; x.lp = lp; x.ec = ec; x.gap = gap;
    q.push_back(x);
  endtask

  // one div_clk period; the expectation is for the rise that starts it, which measures the previous period
  task automatic per(int h, int l, bit lk, bit err, int lp, int ec);
    expect_ev(1'b1, err, lk, lp, ec, 0);
    div_clk_in = 1'b1;
    repeat (h) tick();
    div_clk_in = 1'b0;
    repeat (l) tick();
  endtask

  // from IDLE/SEARCH: first edge (period unknown) then four good periods, locking on the fifth edge
  task automatic acquire(int ec);
    per(2, 2, 1'b0, 1'b0, -1, ec);
    repeat (3) per(2, 2, 1'b0, 1'b0, 4, ec);
    per(2, 2, 1'b1, 1'b0, 4, ec);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_rise_pulse"}, rise_pulse, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_phase"}, phase, 0);
    check({tag, "_last_period"}, last_period, 0);
    check({tag, "_period_err"}, period_err, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    enable = 1'b1;
    tick();
    // 1) clk/4 locks on the fifth edge, then phase runs 0..3
    acquire(0);
    chk_phase = 1'b1;
    repeat (3) per(2, 2, 1'b1, 1'b0, 4, 0);
    chk_phase = 1'b0;
    // 2) one stretched period drops lock, four good periods relock
    per(3, 2, 1'b1, 1'b0, 4, 0);
    per(2, 2, 1'b0, 1'b1, 5, 1);
    repeat (3) per(2, 2, 1'b0, 1'b0, 4, 1);
    per(2, 2, 1'b1, 1'b0, 4, 1);
    // 3) div clock stops low: timeout 9 clk after the last rise_pulse (cnt reaches 8), then relock
    per(2, 2, 1'b1, 1'b0, 4, 1);
    expect_ev(1'b0, 1'b1, 1'b0, 4, 2, 9);
    repeat (20) tick();
    acquire(2);
    // 4) one-cycle reset mid-lock clears everything at once
    tick();
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    tick();
    reset = 1'b0;
    acquire(0);
    // 5) enable falls in the same cycle as the rise ending a bad period: no error, no update
    per(3, 2, 1'b1, 1'b0, 4, 0);
    expect_ev(1'b1, 1'b0, 1'b0, 4, 0, 0);
    div_clk_in = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    tick();
    check("disable_locked", locked, 0);
    check("disable_phase", phase, 0);
    check("disable_period_err", period_err, 0);
    tick();
    div_clk_in = 1'b0;
    repeat (3) tick();
    per(2, 2, 1'b0, 1'b0, 4, 0);
    tick();
    enable = 1'b1;
    acquire(0);
    // 6) 300 lock-breaking errors: err_count saturates at 255
    for (int k = 1; k <= 300; k++) begin
      per(3, 2, 1'b1, 1'b0, 4, (k - 1 > 255) ? 255 : k - 1);
      per(2, 2, 1'b0, 1'b1, 5, (k > 255) ? 255 : k);
      repeat (3) per(2, 2, 1'b0, 1'b0, 4, (k > 255) ? 255 : k);
    end
    per(2, 2, 1'b1, 1'b0, 4, 255);
    check("final_err_count", err_count, 255);
    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
